// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types, constants and saturation helper for the encoder velocity sampler
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    MEASURE
  } sampler_state_e;

  // Shortest window the sampler will run; smaller programmed periods are raised to this.
  localparam int MIN_PERIOD = 2;

  // Clamp a sign-extended delta into the signed range of a vel_width-bit result.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] delta,
                                                    input int vel_width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (vel_width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (delta > max_v) begin
      return max_v;
    end else if (delta < min_v) begin
      return min_v;
    end else begin
      return delta;
    end
  endfunction

endpackage

// File: rtl/encoder_velocity_sampler_window_timer.sv
// rtl/encoder_velocity_sampler_window_timer.sv - loadable down-counter with terminal-count flag
module window_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Reload has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/encoder_velocity_sampler.sv
// rtl/encoder_velocity_sampler.sv - windowed encoder delta sampler with saturation, handshake and stall tracking
module encoder_velocity_sampler
  import encoder_pkg::*;
#(
  parameter int COUNT_WIDTH   = 32,
  parameter int PERIOD_WIDTH  = 24,
  parameter int VEL_WIDTH     = 16,
  parameter int STALL_WINDOWS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [COUNT_WIDTH-1:0]  encoder_count,
  input  logic                    state_change,
  output logic [VEL_WIDTH-1:0]    velocity,
  output logic                    velocity_valid,
  input  logic                    velocity_ready,
  output logic                    overrun,
  output logic                    stalled,
  output logic [15:0]             window_count
);

  sampler_state_e state, state_next;

  logic                    tc;
  logic                    prime;
  logic                    active;
  logic                    window_end;
  logic                    timer_load;
  logic                    timer_dec;
  logic [PERIOD_WIDTH-1:0] period_eff;
  logic [PERIOD_WIDTH-1:0] reload_value;
  logic [COUNT_WIDTH-1:0]  base;
  logic [COUNT_WIDTH-1:0]  delta;
  logic [VEL_WIDTH-1:0]    vel_sat;
  logic [7:0]              stall_cnt;
  logic [8:0]              stall_next;
  logic                    window_moved;

  assign period_eff   = (period < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : period;
  assign reload_value = period_eff - PERIOD_WIDTH'(1);
  // Modular subtraction makes counter wrap transparent; the result is read as signed.
  assign delta        = encoder_count - base;
  assign vel_sat      = VEL_WIDTH'(sat_signed(64'($signed(delta)), VEL_WIDTH));
  assign stall_next   = {1'b0, stall_cnt} + 9'd1;

  assign timer_load   = prime || window_end;
  assign timer_dec    = active && !tc;

  window_timer #(
    .WIDTH (PERIOD_WIDTH)
  ) u_window_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (reload_value),
    .dec        (timer_dec),
    .tc         (tc)
  );

  // Sampler state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle strobes; dropping enable aborts from any state.
  always_comb begin
    state_next = state;
    prime      = 1'b0;
    active     = 1'b0;
    window_end = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = PRIME;
        PRIME: begin
          prime      = 1'b1;
          state_next = MEASURE;
        end
        MEASURE: begin
          active     = 1'b1;
          window_end = tc;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Base capture, window counting and the single-entry output sample with overwrite detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base           <= '0;
      velocity       <= '0;
      velocity_valid <= 1'b0;
      overrun        <= 1'b0;
      window_count   <= '0;
    end else begin
      overrun <= 1'b0;
      if (prime || window_end) begin
        base <= encoder_count;
      end
      if (prime) begin
        window_count <= '0;
      end else if (window_end) begin
        window_count <= window_count + 16'd1;
      end
      if (window_end) begin
        velocity       <= vel_sat;
        velocity_valid <= 1'b1;
        overrun        <= velocity_valid && !velocity_ready;
      end else if (velocity_valid && velocity_ready) begin
        velocity_valid <= 1'b0;
      end
    end
  end

  // Stall tracking: movement clears at once, empty windows count up to the threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      stalled      <= 1'b0;
      window_moved <= 1'b0;
    end else if (!active) begin
      stall_cnt    <= '0;
      stalled      <= 1'b0;
      window_moved <= 1'b0;
    end else if (state_change) begin
      stall_cnt    <= '0;
      stalled      <= 1'b0;
      window_moved <= !window_end;
    end else if (window_end) begin
      window_moved <= 1'b0;
      if (!window_moved) begin
        if (stall_cnt < 8'(STALL_WINDOWS)) begin
          stall_cnt <= stall_cnt + 8'd1;
        end
        stalled <= (stall_next >= 9'(STALL_WINDOWS));
      end
    end
  end

endmodule

// File: doc/encoder_velocity_sampler.md
Name: encoder_velocity_sampler

Overview:
Periodic sampler that sits between the quadrature encoder counter and the velocity PID loop.
- Slices time into fixed windows of a programmable number of clk cycles.
- At each window end, captures the change in encoder count as a saturated signed velocity.
- Presents each velocity sample on a valid/ready handshake.
- Tracks stall status and flags samples the consumer did not accept in time.

Parameters:
COUNT_WIDTH, 32, width of the encoder count input
PERIOD_WIDTH, 24, width of the window-length configuration
VEL_WIDTH, 16, width of the signed velocity output
STALL_WINDOWS, 8, number of consecutive edge-free windows before stalled asserts (1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run sampler; low forces IDLE
period  input  PERIOD_WIDTH  window length in clk cycles; latched at every window start
encoder_count  input  COUNT_WIDTH  free-running encoder count, synchronous to clk
state_change  input  1  one-cycle indication that the encoder state moved this cycle
velocity  output  VEL_WIDTH  signed counts per window, saturated
velocity_valid  output  1  velocity holds an unconsumed sample
velocity_ready  input  1  consumer accepts the sample when valid & ready
overrun  output  1  one-cycle pulse: an unconsumed sample was overwritten
stalled  output  1  no encoder movement for STALL_WINDOWS full windows
window_count  output  16  number of completed windows since enable rose; wraps

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timer/base/stall counter 0. Reset is legal mid-window and mid-handshake, and discards everything.
- FSM states:
  - IDLE: enable=0. Timer held.
  - PRIME: one cycle after enable is seen high.
    - base <= encoder_count
    - period_q <= max(period, 2)
    - timer <= period_q_next - 1
    - window_count <= 0
    - goes to MEASURE
  - MEASURE: timer decrements each cycle. On the cycle with timer==0 (window end):
    - delta = encoder_count - base, modulo 2^COUNT_WIDTH, interpreted as signed.
    - velocity_reg <= delta saturated to [-2^(VEL_WIDTH-1), 2^(VEL_WIDTH-1)-1].
    - base <= encoder_count (same cycle, so no counts are lost across windows).
    - period_q <= max(period, 2); timer <= that value - 1.
    - window_count increments.
  - enable low in any state -> IDLE on the next cycle. The partial window is discarded. A pending valid sample stays until accepted.
- Window length: exactly period_q cycles, with window ends period_q cycles apart. A period change takes effect at the next window boundary only. period of 0 or 1 is treated as 2.
- Handshake:
  - velocity and velocity_valid are registered and update the cycle after the window end (latency 1).
  - velocity_valid clears the cycle after a cycle with valid & ready, unless a new sample lands that same cycle; in that case valid stays 1 and the new value is shown.
  - velocity is stable while valid=1 & ready=0, except on an overwrite.
  - A new sample arriving while valid=1 and not accepted in that cycle overwrites the old one, and overrun pulses for 1 cycle (aligned with the new valid data).
- Stall:
  - window_moved is set by any state_change within the window.
  - At a window end with window_moved=0: stall_cnt increments, saturating at STALL_WINDOWS. stalled <= (stall_cnt+1 >= STALL_WINDOWS).
  - Any state_change clears stall_cnt and deasserts stalled on the next cycle, without waiting for a window end.
  - Stall status is cleared in IDLE and PRIME.
- Simultaneous events:
  - state_change on the window-end cycle counts toward the ending window.
  - A consumer accept and a new sample in the same cycle produce no overrun.

Decomposition:
- Package encoder_pkg holds:
  - sampler FSM enum {IDLE, PRIME, MEASURE}
  - constant MIN_PERIOD = 2
  - function sat_signed(delta, VEL_WIDTH) for signed saturation
- Sub-module window_timer: loadable down-counter with a reload value and a terminal-count pulse output; instantiated once.

Test Plan:
- Steady forward motion: period=100, encoder_count +3 every 10 cycles -> velocity=30 every 100 cycles, valid latency 1 after window end, overrun=0.
- Reverse and wrap: base=0x00000005, count falls by 10 across the window to 0xFFFFFFFB -> velocity=-10 (0xFFF6).
- Saturation: +40000 counts in one window -> velocity=32767; -40000 counts -> velocity=-32768.
- Backpressure: ready=0 for 2 windows -> second sample overwrites the first with a 1-cycle overrun pulse; ready=1 then clears valid the next cycle.
- Stall: STALL_WINDOWS=8, no state_change -> stalled rises after the 8th window end; a single state_change -> stalled=0 on the next cycle.
- Reconfig/abort: period changed 100->50 mid-window -> current window still 100 cycles, next window 50. enable dropped mid-window -> no sample produced. Async reset mid-window -> all outputs 0 immediately.
